// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes,
// FSM state encoding and the conditional two's-complement helpers.
package hilo_muldiv_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_SIGN = 2'd2
   } md_state_t;

   function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
      return en ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
      return en ? (~v + 64'd1) : v;
   endfunction

endpackage

// File: rtl/hilo_muldiv.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Signed ops run on magnitudes; the sign is restored in the final SIGN cycle.
module hilo_muldiv
   import hilo_muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Start,
   input  logic [2:0]  MDOp,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   output logic        Busy,
   output logic        Done,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   md_state_t   r_state;
   md_state_t   w_state_next;
   logic [63:0] r_acc;
   logic [31:0] r_opb;
   logic [4:0]  r_cnt;
   logic        r_is_div;
   logic        r_neg_q;
   logic        r_neg_r;
   logic        r_done;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic        w_idle;
   logic        w_start_iter;
   logic        w_start_mt;
   logic        w_signed_op;
   logic        w_a_neg;
   logic        w_b_neg;
   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;
   logic [32:0] w_mul_sum;
   logic [63:0] w_mul_next;
   logic        w_div_ok;
   logic [31:0] w_div_diff;
   logic [63:0] w_div_next;
   logic [63:0] w_prod;
   logic [31:0] w_quo;
   logic [31:0] w_rem;

   assign w_idle       = (r_state == ST_IDLE);
   assign w_start_iter = Start && w_idle && !MDOp[2];
   assign w_start_mt   = Start && w_idle && ((MDOp == MD_MTHI) || (MDOp == MD_MTLO));
   assign w_signed_op  = (MDOp == MD_MULT) || (MDOp == MD_DIV);
   assign w_a_neg      = w_signed_op && SrcA[31];
   assign w_b_neg      = w_signed_op && SrcB[31];
   assign w_mag_a      = neg32(SrcA, w_a_neg);
   assign w_mag_b      = neg32(SrcB, w_b_neg);

   // Shift-add: multiplier sits in acc[31:0] and is consumed LSB first.
   assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
   assign w_mul_next = {w_mul_sum, r_acc[31:1]};

   // Restoring divide: the shifted remainder is 33 bits wide, but the
   // difference always fits in 32 bits whenever the subtraction is kept.
   assign w_div_ok   = (r_acc[63:31] >= {1'b0, r_opb});
   assign w_div_diff = r_acc[62:31] - r_opb;
   assign w_div_next = w_div_ok ? {w_div_diff, r_acc[30:0], 1'b1}
                                : {r_acc[62:0], 1'b0};

   assign w_prod = neg64(r_acc, r_neg_q);
   assign w_quo  = neg32(r_acc[31:0], r_neg_q);
   assign w_rem  = neg32(r_acc[63:32], r_neg_r);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_IDLE: if (w_start_iter) w_state_next = ST_CALC;
         ST_CALC: if (r_cnt == 5'd0) w_state_next = ST_SIGN;
         ST_SIGN: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      Busy = (r_state != ST_IDLE);
      Done = r_done;
      HI   = r_hi;
      LO   = r_lo;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc    <= 64'd0;
         r_opb    <= 32'd0;
         r_cnt    <= 5'd0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_done   <= 1'b0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_start_iter) begin
                  // High half cleared; low half carries the multiplier or dividend.
                  r_acc    <= {32'd0, w_mag_a};
                  r_opb    <= w_mag_b;
                  r_cnt    <= 5'd31;
                  r_is_div <= MDOp[1];
                  // A zero divisor must leave the all-ones quotient unnegated.
                  r_neg_q  <= (w_a_neg ^ w_b_neg) && (SrcB != 32'd0);
                  r_neg_r  <= w_a_neg;
               end else if (w_start_mt) begin
                  if (MDOp == MD_MTHI) r_hi <= SrcA;
                  else                 r_lo <= SrcA;
               end
            end
            ST_CALC: begin
               r_acc <= r_is_div ? w_div_next : w_mul_next;
               r_cnt <= r_cnt - 5'd1;
            end
            ST_SIGN: begin
               if (r_is_div) begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end else begin
                  r_hi <= w_prod[63:32];
                  r_lo <= w_prod[31:0];
               end
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: a directed vector table plus
// hand-written sequences for MTHI/MTLO, Busy interaction and reset abort.
module tb_hilo_muldiv;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   logic        clk;
   logic        rst_n;
   logic        Start;
   logic [2:0]  MDOp;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        Busy;
   logic        Done;
   logic [31:0] HI;
   logic [31:0] LO;

   int n_checks;
   int n_errors;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[11];

   hilo_muldiv dut (
      .clk   (clk),
      .rst_n (rst_n),
      .Start (Start),
      .MDOp  (MDOp),
      .SrcA  (SrcA),
      .SrcB  (SrcB),
      .Busy  (Busy),
      .Done  (Done),
      .HI    (HI),
      .LO    (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive a Start strobe; returns 1 time unit after the sampling edge.
   task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      Start = 1'b1;
      MDOp  = op;
      SrcA  = a;
      SrcB  = b;
      @(posedge clk);
      #1;
      Start = 1'b0;
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      while (Done !== 1'b1 && cycles < 40) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic run_vec(input int idx);
      logic [31:0] hi_before;
      int cycles;
      hi_before = HI;
      start_op(vecs[idx].op, vecs[idx].a, vecs[idx].b);
      check32($sformatf("v%0d_busy_start", idx), {31'd0, Busy}, 32'd1);
      cycles = 0;
      while (Done !== 1'b1 && cycles < 40) begin
         @(posedge clk);
         #1;
         cycles++;
         if (cycles == 16) begin
            check32($sformatf("v%0d_hi_hold", idx), HI, hi_before);
            check32($sformatf("v%0d_busy_mid", idx), {31'd0, Busy}, 32'd1);
         end
      end
      check32($sformatf("v%0d_latency", idx), cycles, 32'd33);
      check32($sformatf("v%0d_hi", idx), HI, vecs[idx].hi);
      check32($sformatf("v%0d_lo", idx), LO, vecs[idx].lo);
      check32($sformatf("v%0d_busy_done", idx), {31'd0, Busy}, 32'd0);
      $display("vec %0d op=%0d a=%h b=%h -> HI=%h LO=%h cycles=%0d",
               idx, vecs[idx].op, vecs[idx].a, vecs[idx].b, HI, LO, cycles);
      @(posedge clk);
      #1;
      check32($sformatf("v%0d_done_pulse", idx), {31'd0, Done}, 32'd0);
   endtask

   initial begin
      int cycles;
      int done_seen;
      n_checks = 0;
      n_errors = 0;
      Start = 1'b0;
      MDOp  = 3'd0;
      SrcA  = 32'd0;
      SrcB  = 32'd0;
      rst_n = 1'b0;

      vecs[0]  = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
      vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
      vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[4]  = '{OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
      vecs[5]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
      vecs[6]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
      vecs[7]  = '{OP_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[8]  = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
      vecs[9]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[10] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};

      repeat (2) @(posedge clk);
      #1;
      check32("rst_hi", HI, 32'd0);
      check32("rst_lo", LO, 32'd0);
      check32("rst_busy", {31'd0, Busy}, 32'd0);
      check32("rst_done", {31'd0, Done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) run_vec(i);

      // MTHI / MTLO single-cycle moves, and a no-op code.
      start_op(OP_MTLO, 32'h00000055, 32'd0);
      check32("mtlo_lo", LO, 32'h00000055);
      start_op(OP_MTHI, 32'h12345678, 32'd0);
      check32("mthi_hi", HI, 32'h12345678);
      check32("mthi_busy", {31'd0, Busy}, 32'd0);
      check32("mthi_done", {31'd0, Done}, 32'd0);
      $display("mt: HI=%h LO=%h", HI, LO);
      start_op(3'd6, 32'hDEADBEEF, 32'h1);
      check32("nop_hi", HI, 32'h12345678);
      check32("nop_lo", LO, 32'h00000055);
      check32("nop_busy", {31'd0, Busy}, 32'd0);
      $display("nop: HI=%h LO=%h", HI, LO);

      // MTHI attempted while a MULT is in flight must be ignored.
      start_op(OP_MULT, 32'h00000003, 32'h00000005);
      repeat (9) @(posedge clk);
      @(negedge clk);
      Start = 1'b1;
      MDOp  = OP_MTHI;
      SrcA  = 32'hAAAA0000;
      @(posedge clk);
      #1;
      Start = 1'b0;
      check32("busy_mthi_ignored", HI, 32'h12345678);
      wait_done(cycles);
      check32("busy_mult_latency", cycles, 32'd23);
      check32("busy_mult_hi", HI, 32'h00000000);
      check32("busy_mult_lo", LO, 32'h0000000F);
      $display("mult during mthi attempt: HI=%h LO=%h", HI, LO);
      start_op(OP_MTHI, 32'hAAAA0000, 32'd0);
      check32("mthi_after_hi", HI, 32'hAAAA0000);
      $display("mthi after done: HI=%h", HI);

      // Back-to-back: Start in the cycle Done is high.
      start_op(OP_MULTU, 32'h00000002, 32'h00000003);
      wait_done(cycles);
      check32("b2b_first_lo", LO, 32'h00000006);
      Start = 1'b1;
      MDOp  = OP_MULTU;
      SrcA  = 32'h00000004;
      SrcB  = 32'h00000005;
      @(posedge clk);
      #1;
      Start = 1'b0;
      check32("b2b_busy", {31'd0, Busy}, 32'd1);
      check32("b2b_done_low", {31'd0, Done}, 32'd0);
      wait_done(cycles);
      check32("b2b_latency", cycles, 32'd33);
      check32("b2b_second_lo", LO, 32'h00000014);
      $display("back-to-back: LO=%h cycles=%0d", LO, cycles);

      // Asynchronous reset in the middle of a DIV aborts it.
      start_op(OP_DIV, 32'h00000064, 32'h00000007);
      repeat (19) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check32("abort_hi", HI, 32'd0);
      check32("abort_lo", LO, 32'd0);
      check32("abort_busy", {31'd0, Busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (Done === 1'b1) done_seen++;
      end
      check32("abort_no_done", done_seen, 32'd0);
      check32("abort_hi_after", HI, 32'd0);
      $display("reset abort: HI=%h LO=%h Busy=%b", HI, LO, Busy);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
